// File: rtl/instruction_sequencer_if.sv
// Instruction-fetch and data-memory handshake bundle between the sequencer (master) and memory (slave).
// Request lines are driven by the sequencer; valid/done pulses are returned by memory.
interface instruction_sequencer_if #(
    parameter int PC_WIDTH = 32
);
    logic                imem_req;
    logic [PC_WIDTH-1:0] imem_addr;
    logic                imem_valid;
    logic [31:0]         imem_data;
    logic                dmem_req;
    logic                dmem_done;

    modport master (
        output imem_req, imem_addr, dmem_req,
        input  imem_valid, imem_data, dmem_done
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req,
        output imem_valid, imem_data, dmem_done
    );
endinterface

// File: rtl/instruction_sequencer.sv
// Multi-cycle fetch/decode/memory/update sequencer feeding the register-file control block.
// Stalls in IFETCH until imem_valid and in MEMORY (LOAD/STORE) until dmem_done; HALT is absorbing until reset.
module instruction_sequencer #(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    instruction_sequencer_if.master mem,
    input  logic [31:0]             jump_condition,
    input  logic [31:0]             jump_target,
    output logic [2:0]              stage,
    output logic [4:0]              current_instruction_type,
    output logic [4:0]              reg_dst,
    output logic [4:0]              reg_src0,
    output logic [4:0]              reg_src1,
    output logic [31:0]             imm,
    output logic [PC_WIDTH-1:0]     pc,
    output logic                    halted,
    output logic [31:0]             retired_count
);
    typedef enum logic [2:0] {
        STAGE_IFETCH          = 3'd0,
        STAGE_DECODE          = 3'd1,
        STAGE_MEMORY          = 3'd2,
        STAGE_REGISTER_UPDATE = 3'd3,
        STAGE_UPDATE_PC       = 3'd4,
        STAGE_HALTED          = 3'd5
    } stage_e;

    localparam logic [4:0] TYPE_LOAD  = 5'd2;
    localparam logic [4:0] TYPE_STORE = 5'd3;
    localparam logic [4:0] TYPE_JUMP  = 5'd5;
    localparam logic [4:0] TYPE_HALT  = 5'd6;

    stage_e              stage_q;
    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_d;
    logic [31:0]         ir_q;
    logic [31:0]         retired_q;
    logic                halted_q;
    logic                dmem_req_q;
    logic                is_mem;
    logic                take_jump;

    assign is_mem    = (ir_q[4:0] == TYPE_LOAD) || (ir_q[4:0] == TYPE_STORE);
    assign take_jump = (ir_q[4:0] == TYPE_JUMP) && (jump_condition != 32'd0);

    // Codes 7..31 fall through every stage with no side effects, i.e. they behave as NO_OP.
    always_comb begin
        pc_d = pc_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};
        if (take_jump) begin
            pc_d = jump_target[PC_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q    <= STAGE_IFETCH;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            retired_q  <= '0;
            halted_q   <= 1'b0;
            dmem_req_q <= 1'b0;
        end else begin
            case (stage_q)
                STAGE_IFETCH: begin
                    if (mem.imem_valid) begin
                        ir_q    <= mem.imem_data;
                        stage_q <= STAGE_DECODE;
                    end
                end
                STAGE_DECODE: begin
                    if (ir_q[4:0] == TYPE_HALT) begin
                        stage_q  <= STAGE_HALTED;
                        halted_q <= 1'b1;
                    end else begin
                        stage_q    <= STAGE_MEMORY;
                        dmem_req_q <= is_mem;
                    end
                end
                STAGE_MEMORY: begin
                    // dmem_req stays up through the cycle dmem_done is sampled, then drops.
                    if (!is_mem || mem.dmem_done) begin
                        stage_q    <= STAGE_REGISTER_UPDATE;
                        dmem_req_q <= 1'b0;
                    end
                end
                STAGE_REGISTER_UPDATE: begin
                    stage_q <= STAGE_UPDATE_PC;
                end
                STAGE_UPDATE_PC: begin
                    pc_q      <= pc_d;
                    retired_q <= retired_q + 32'd1;
                    stage_q   <= STAGE_IFETCH;
                end
                STAGE_HALTED: begin
                    stage_q <= STAGE_HALTED;
                end
                default: begin
                    stage_q <= STAGE_IFETCH;
                end
            endcase
        end
    end

    assign mem.imem_req  = (stage_q == STAGE_IFETCH);
    assign mem.imem_addr = pc_q;
    assign mem.dmem_req  = dmem_req_q;

    assign stage                    = stage_q;
    assign current_instruction_type = ir_q[4:0];
    assign reg_dst                  = ir_q[9:5];
    assign reg_src0                 = ir_q[14:10];
    assign reg_src1                 = ir_q[19:15];
    assign imm                      = {15'b0, ir_q[31:15]};
    assign pc                       = pc_q;
    assign halted                   = halted_q;
    assign retired_count            = retired_q;
endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer: expected pc/retired_count per instruction go through a scoreboard queue.
module tb_instruction_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] jump_condition;
    logic [31:0] jump_target;
    logic [2:0]  stage;
    logic [4:0]  cur_type;
    logic [4:0]  reg_dst;
    logic [4:0]  reg_src0;
    logic [4:0]  reg_src1;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        halted;
    logic [31:0] retired_count;

    instruction_sequencer_if #(.PC_WIDTH(32)) mif ();

    instruction_sequencer #(.PC_WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .mem                      (mif),
        .jump_condition           (jump_condition),
        .jump_target              (jump_target),
        .stage                    (stage),
        .current_instruction_type (cur_type),
        .reg_dst                  (reg_dst),
        .reg_src0                 (reg_src0),
        .reg_src1                 (reg_src1),
        .imm                      (imm),
        .pc                       (pc),
        .halted                   (halted),
        .retired_count            (retired_count)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ret;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] m_pc;
    logic [31:0] m_ret;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Runs one non-HALT instruction from IFETCH back to IFETCH, checking every stage on the way.
    task automatic run_instr(input logic [31:0] word, input logic [31:0] jc,
                             input logic [31:0] jt, input int delay);
        logic [4:0] t;
        bit         is_mem;
        exp_t       e;
        t      = word[4:0];
        is_mem = (t == 5'd2) || (t == 5'd3);
        chk("ifetch_stage", 32'(stage), 32'd0);
        chk("ifetch_imem_req", 32'(mif.imem_req), 32'd1);
        chk("ifetch_imem_addr", mif.imem_addr, m_pc);
        e.pc  = (t == 5'd5 && jc != 32'd0) ? jt : m_pc + 32'd1;
        e.ret = m_ret + 32'd1;
        sb.push_back(e);
        jump_condition  = jc;
        jump_target     = jt;
        mif.imem_valid  = 1'b1;
        mif.imem_data   = word;
        @(negedge clk);
        mif.imem_valid  = 1'b0;
        mif.imem_data   = 32'hDEAD_BEEF;
        chk("decode_stage", 32'(stage), 32'd1);
        chk("decode_type", 32'(cur_type), 32'(word[4:0]));
        chk("decode_reg_dst", 32'(reg_dst), 32'(word[9:5]));
        chk("decode_reg_src0", 32'(reg_src0), 32'(word[14:10]));
        chk("decode_reg_src1", 32'(reg_src1), 32'(word[19:15]));
        chk("decode_imm", imm, {15'b0, word[31:15]});
        @(negedge clk);
        if (is_mem) begin
            for (int i = 0; i < delay; i++) begin
                chk("mem_wait_stage", 32'(stage), 32'd2);
                chk("mem_wait_dmem_req", 32'(mif.dmem_req), 32'd1);
                @(negedge clk);
            end
            chk("mem_done_stage", 32'(stage), 32'd2);
            chk("mem_done_dmem_req", 32'(mif.dmem_req), 32'd1);
            mif.dmem_done = 1'b1;
            @(negedge clk);
            mif.dmem_done = 1'b0;
        end else begin
            chk("mem_stage", 32'(stage), 32'd2);
            chk("mem_dmem_req_low", 32'(mif.dmem_req), 32'd0);
            @(negedge clk);
        end
        chk("regupd_stage", 32'(stage), 32'd3);
        chk("regupd_dmem_req", 32'(mif.dmem_req), 32'd0);
        @(negedge clk);
        chk("updpc_stage", 32'(stage), 32'd4);
        chk("updpc_type_stable", 32'(cur_type), 32'(word[4:0]));
        chk("updpc_retired_before", retired_count, m_ret);
        @(negedge clk);
        e = sb.pop_front();
        chk("retire_stage", 32'(stage), 32'd0);
        chk("retire_pc", pc, e.pc);
        chk("retire_imem_addr", mif.imem_addr, e.pc);
        chk("retire_count", retired_count, e.ret);
        m_pc  = e.pc;
        m_ret = e.ret;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst            = 1'b1;
        mif.imem_valid = 1'b0;
        mif.imem_data  = 32'h0;
        mif.dmem_done  = 1'b0;
        jump_condition = 32'h0;
        jump_target    = 32'h0;
        m_pc           = 32'h0;
        m_ret          = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_stage", 32'(stage), 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_retired", retired_count, 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_imem_req", 32'(mif.imem_req), 32'd1);
        chk("rst_dmem_req", 32'(mif.dmem_req), 32'd0);
        chk("rst_ir_type", 32'(cur_type), 32'd0);
        rst = 1'b0;

        run_instr(32'h1 | (32'd5 << 5) | (32'h1234 << 15), 32'd0, 32'd0, 0);
        run_instr(32'd2 | (32'd3 << 5) | (32'd7 << 10), 32'd0, 32'd0, 3);
        run_instr(32'd5 | (32'd1 << 10) | (32'd2 << 15), 32'd7, 32'h40, 0);
        run_instr(32'd5 | (32'd1 << 10) | (32'd2 << 15), 32'd0, 32'h80, 0);
        run_instr(32'd3 | (32'd4 << 10) | (32'd9 << 15), 32'd0, 32'd0, 0);
        run_instr(32'h1F | (32'd17 << 5), 32'd1, 32'h99, 0);

        // Fetch withheld; a stray dmem_done in IFETCH must not move anything.
        for (int i = 0; i < 10; i++) begin
            mif.dmem_done = (i == 4);
            @(negedge clk);
            chk("stall_stage", 32'(stage), 32'd0);
        end
        mif.dmem_done = 1'b0;
        chk("stall_pc", pc, m_pc);
        chk("stall_retired", retired_count, m_ret);

        run_instr(32'd5, 32'd1, 32'hFFFF_FFFF, 0);
        run_instr(32'd0, 32'd0, 32'd0, 0);

        // Reset in the middle of a STORE's MEMORY stall.
        mif.imem_valid = 1'b1;
        mif.imem_data  = 32'd3 | (32'd1 << 10);
        @(negedge clk);
        mif.imem_valid = 1'b0;
        @(negedge clk);
        chk("store_mem_stage", 32'(stage), 32'd2);
        chk("store_mem_dmem_req", 32'(mif.dmem_req), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        m_pc  = 32'h0;
        m_ret = 32'h0;
        chk("midrst_stage", 32'(stage), 32'd0);
        chk("midrst_pc", pc, 32'h0);
        chk("midrst_dmem_req", 32'(mif.dmem_req), 32'd0);
        chk("midrst_retired", retired_count, 32'd0);
        mif.dmem_done = 1'b1;
        @(negedge clk);
        mif.dmem_done = 1'b0;
        chk("late_done_stage", 32'(stage), 32'd0);
        chk("late_done_dmem_req", 32'(mif.dmem_req), 32'd0);

        // imem_valid coinciding with reset is dropped.
        rst            = 1'b1;
        mif.imem_valid = 1'b1;
        mif.imem_data  = 32'h1 | (32'd5 << 5);
        @(negedge clk);
        rst            = 1'b0;
        mif.imem_valid = 1'b0;
        chk("rst_valid_stage", 32'(stage), 32'd0);
        chk("rst_valid_type", 32'(cur_type), 32'd0);

        run_instr(32'h1 | (32'd2 << 5) | (32'h5 << 15), 32'd0, 32'd0, 0);

        // HALT: absorbing, pc and retired_count frozen.
        mif.imem_valid = 1'b1;
        mif.imem_data  = 32'd6;
        @(negedge clk);
        mif.imem_valid = 1'b0;
        chk("halt_decode_stage", 32'(stage), 32'd1);
        @(negedge clk);
        chk("halt_stage", 32'(stage), 32'd5);
        chk("halt_flag", 32'(halted), 32'd1);
        for (int i = 0; i < 20; i++) begin
            mif.imem_valid = (i == 3);
            mif.dmem_done  = (i == 7);
            @(negedge clk);
        end
        mif.imem_valid = 1'b0;
        mif.dmem_done  = 1'b0;
        chk("halt_hold_stage", 32'(stage), 32'd5);
        chk("halt_hold_flag", 32'(halted), 32'd1);
        chk("halt_hold_pc", pc, m_pc);
        chk("halt_hold_retired", retired_count, m_ret);
        chk("halt_imem_req", 32'(mif.imem_req), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
